sram_port_arbiter: RTL

Round-robin arbiter that shares one single-port SRAM macro (one-cycle read latency, byte enables) between NUM_REQ independent req/gnt/rvalid requesters, e.g. instruction fetch, data port and debug. It grants at most one access per cycle and steers the SRAM response back to the issuing port. Each port has a response hold register, so a requester that stalls its rready_i blocks only itself, never the SRAM or the other ports.

---
 rtl/sram_port_arbiter.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/sram_port_arbiter.sv
// ---------------------------------------------------------------------------
// sram_port_arbiter
//
// Shares one single-port SRAM macro (one-cycle read latency, byte enables)
// between NUM_REQ req/gnt/rvalid requesters using a round-robin search. At
// most one access is issued per cycle. The response is steered back to the
// port that issued it. Each port owns a response hold register, so a port
// that stalls its rready_i blocks only itself.
//
// Ports (port p occupies slice p of every packed per-port vector):
//   clk_i, rst_i          clock; asynchronous active-high reset
//   req_i, we_i           per-port request and write enable
//   addr_i, wdata_i, be_i per-port word address, write data, byte enables
//   gnt_o                 per-port grant (combinational, one-hot or zero)
//   rvalid_o, rdata_o     per-port response valid and data
//   rready_i              per-port response accept
//   sram_req_o, sram_we_o, sram_addr_o, sram_wdata_o, sram_be_o
//                         SRAM command, driven by the granted port
//   sram_rdata_i          SRAM read data, valid the cycle after a read strobe
// ---------------------------------------------------------------------------
module sram_port_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [NUM_REQ-1:0]               req_i,
  input  logic [NUM_REQ-1:0]               we_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    wdata_i,
  input  logic [NUM_REQ*DATA_WIDTH/8-1:0]  be_i,
  output logic [NUM_REQ-1:0]               gnt_o,
  output logic [NUM_REQ-1:0]               rvalid_o,
  output logic [NUM_REQ*DATA_WIDTH-1:0]    rdata_o,
  input  logic [NUM_REQ-1:0]               rready_i,
  output logic                             sram_req_o,
  output logic                             sram_we_o,
  output logic [ADDR_WIDTH-1:0]            sram_addr_o,
  output logic [DATA_WIDTH-1:0]            sram_wdata_o,
  output logic [DATA_WIDTH/8-1:0]          sram_be_o,
  input  logic [DATA_WIDTH-1:0]            sram_rdata_i
);

  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int PTR_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // no response owed
    ST_RESP = 2'd1,  // first response cycle, data straight from the SRAM
    ST_HOLD = 2'd2   // response stalled, data from the hold register
  } port_state_e;

  port_state_e             state_q [NUM_REQ];
  port_state_e             state_d [NUM_REQ];
  logic [DATA_WIDTH-1:0]   hold_q  [NUM_REQ];
  logic [DATA_WIDTH-1:0]   hold_d  [NUM_REQ];
  logic [NUM_REQ-1:0]      is_write_q;
  logic [NUM_REQ-1:0]      is_write_d;
  logic [PTR_W-1:0]        rr_q;
  logic [PTR_W-1:0]        rr_d;

  logic [NUM_REQ-1:0]      eligible;
  logic [NUM_REQ-1:0]      gnt;
  logic                    found;
  logic [PTR_W-1:0]        win_idx;
  logic [PTR_W-1:0]        cand;

  // A port may be granted when it has nothing outstanding, or when its
  // pending response is being accepted in this same cycle.
  always_comb begin
    for (int p = 0; p < NUM_REQ; p++) begin
      eligible[p] = req_i[p] & ((state_q[p] == ST_IDLE) | rready_i[p]);
    end
  end

  // Round-robin search starting at rr_q; the first eligible port wins.
  // Grants are masked while reset is asserted because gnt_o is combinational
  // and must read zero during reset regardless of the inputs.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the block can leave it unassigned and infer a latch.
    found   = 1'b0;
    win_idx = '0;
    cand    = '0;
    gnt     = '0;
    if (!rst_i) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        cand = PTR_W'((32'(rr_q) + 32'(i)) % NUM_REQ);
        if (!found && eligible[cand]) begin
          found   = 1'b1;
          win_idx = cand;
        end
      end
      if (found) begin
        gnt[win_idx] = 1'b1;
      end
    end
  end

  always_comb begin
    rr_d = rr_q;
    if (found) begin
      rr_d = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + PTR_W'(1);
    end
  end

  // SRAM command mux; an idle cycle drives an all-zero command.
  always_comb begin
    sram_req_o   = found;
    sram_we_o    = 1'b0;
    sram_addr_o  = '0;
    sram_wdata_o = '0;
    sram_be_o    = '0;
    for (int p = 0; p < NUM_REQ; p++) begin
      if (gnt[p]) begin
        sram_we_o    = we_i[p];
        sram_addr_o  = addr_i[p*ADDR_WIDTH +: ADDR_WIDTH];
        sram_wdata_o = wdata_i[p*DATA_WIDTH +: DATA_WIDTH];
        sram_be_o    = be_i[p*BE_W +: BE_W];
      end
    end
  end

  // Per-port response state. Only the port in ST_RESP looks at sram_rdata_i,
  // and at most one port can be there since only one access issues per cycle.
  always_comb begin
    for (int p = 0; p < NUM_REQ; p++) begin
      state_d[p]    = state_q[p];
      hold_d[p]     = hold_q[p];
      is_write_d[p] = gnt[p] ? we_i[p] : is_write_q[p];

      case (state_q[p])
        ST_IDLE: begin
          if (gnt[p]) state_d[p] = ST_RESP;
        end
        ST_RESP: begin
          if (gnt[p]) begin
            state_d[p] = ST_RESP;
          end else if (rready_i[p]) begin
            state_d[p] = ST_IDLE;
          end else begin
            // Capture the one-cycle SRAM data before it disappears.
            state_d[p] = ST_HOLD;
            hold_d[p]  = is_write_q[p] ? '0 : sram_rdata_i;
          end
        end
        ST_HOLD: begin
          if (gnt[p]) begin
            state_d[p] = ST_RESP;
          end else if (rready_i[p]) begin
            state_d[p] = ST_IDLE;
          end
        end
        default: state_d[p] = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    for (int p = 0; p < NUM_REQ; p++) begin
      rvalid_o[p] = (state_q[p] != ST_IDLE);
      case (state_q[p])
        ST_RESP: rdata_o[p*DATA_WIDTH +: DATA_WIDTH] = is_write_q[p] ? '0 : sram_rdata_i;
        ST_HOLD: rdata_o[p*DATA_WIDTH +: DATA_WIDTH] = hold_q[p];
        default: rdata_o[p*DATA_WIDTH +: DATA_WIDTH] = '0;
      endcase
    end
  end

  assign gnt_o = gnt;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q       <= '0;
      is_write_q <= '0;
      for (int p = 0; p < NUM_REQ; p++) begin
        state_q[p] <= ST_IDLE;
        // NOTE: the hold registers are small per-port storage that must read
        // back as zero after reset, so they are reset like ordinary flops.
        hold_q[p]  <= '0;
      end
    end else begin
      rr_q       <= rr_d;
      is_write_q <= is_write_d;
      for (int p = 0; p < NUM_REQ; p++) begin
        state_q[p] <= state_d[p];
        hold_q[p]  <= hold_d[p];
      end
    end
  end

endmodule
